// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline memory stage: word type, memory-stage state
// encoding and the word-address helper used for link/snoop comparisons.
package cpu_types_pkg;

    localparam int WORD_ADDR_LSB = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

    // Two byte addresses refer to the same word when everything above the byte offset matches.
    function automatic logic sameWord(input word_t a, input word_t b);
        return a[31:WORD_ADDR_LSB] == b[31:WORD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/mem_access_unit_link_reg.sv
// LL/SC link register: set by a completed LL, cleared by SC completion,
// a coherence invalidate of the linked word, or a local store to that word.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_set,
    input  logic [31:0] i_setAddr,
    input  logic        i_clear,
    input  logic        i_storeHit,
    input  logic [31:0] i_storeAddr,
    input  logic        i_ccinv,
    input  logic [31:0] i_snoopAddr,
    output logic        o_linkValid,
    output logic [31:0] o_linkAddr
);

    logic  r_linkValid;
    word_t r_linkAddr;
    logic  w_snoopHitsLink;
    logic  w_snoopHitsSet;
    logic  w_storeHitsLink;

    assign w_snoopHitsLink = i_ccinv && sameWord(i_snoopAddr, r_linkAddr);
    assign w_snoopHitsSet  = i_ccinv && sameWord(i_snoopAddr, i_setAddr);
    assign w_storeHitsLink = i_storeHit && sameWord(i_storeAddr, r_linkAddr);

    // A snoop hitting the word being linked in the same cycle leaves the link invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_linkValid <= 1'b0;
            r_linkAddr  <= '0;
        end else if (i_set && !w_snoopHitsSet) begin
            r_linkValid <= 1'b1;
            r_linkAddr  <= i_setAddr;
        end else if (i_set || i_clear || w_snoopHitsLink || w_storeHitsLink) begin
            r_linkValid <= 1'b0;
        end
    end

    assign o_linkValid = r_linkValid;
    assign o_linkAddr  = r_linkAddr;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues and holds the data-cache request until dhit,
// stalls upstream meanwhile, resolves LL/SC and holds the sticky halt.
module mem_access_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              LL_in,
    input  logic              SC_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] load_out,
    output logic              memwb_wen,
    output logic              mem_busy,
    output logic              halt_out
);

    mem_state_t r_state;
    mem_state_t w_nextState;

    word_t r_reqAddr;
    word_t r_reqData;
    logic  r_reqRen;
    logic  r_reqWen;
    logic  r_isLl;
    logic  r_isSc;

    logic  w_memOp;
    logic  w_latch;
    logic  w_linkSet;
    logic  w_linkClear;
    logic  w_storeHit;
    logic  w_linkValid;
    word_t w_linkAddr;

    assign w_memOp = valid_in && (dREN_in || dWEN_in);

    link_reg u_linkReg (
        .CLK         (CLK),
        .nRST        (nRST),
        .i_set       (w_linkSet),
        .i_setAddr   (r_reqAddr),
        .i_clear     (w_linkClear),
        .i_storeHit  (w_storeHit),
        .i_storeAddr (r_reqAddr),
        .i_ccinv     (ccinv),
        .i_snoopAddr (ccsnoopaddr),
        .o_linkValid (w_linkValid),
        .o_linkAddr  (w_linkAddr)
    );

    always_comb begin
        w_nextState = r_state;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        dmemaddr    = '0;
        dmemstore   = '0;
        load_out    = '0;
        memwb_wen   = 1'b1;
        mem_busy    = 1'b0;
        halt_out    = 1'b0;
        w_latch     = 1'b0;
        w_linkSet   = 1'b0;
        w_linkClear = 1'b0;
        w_storeHit  = 1'b0;

        case (r_state)
            IDLE: begin
                if (valid_in && halt_in) begin
                    w_nextState = HALTED;
                end else if (w_memOp) begin
                    // An SC without a matching link retires at once and never touches the cache.
                    if (SC_in && !(w_linkValid && sameWord(w_linkAddr, addr_in))) begin
                        w_linkClear = 1'b1;
                    end else begin
                        mem_busy    = 1'b1;
                        memwb_wen   = 1'b0;
                        w_latch     = 1'b1;
                        w_nextState = ACCESS;
                    end
                end
            end
            ACCESS: begin
                dmemREN   = r_reqRen;
                dmemWEN   = r_reqWen;
                dmemaddr  = r_reqAddr;
                dmemstore = r_reqData;
                if (dhit) begin
                    load_out    = r_isSc ? {31'd0, w_linkValid && sameWord(w_linkAddr, r_reqAddr)}
                                         : dmemload;
                    w_linkSet   = r_isLl;
                    w_linkClear = r_isSc;
                    w_storeHit  = r_reqWen && !r_isSc;
                    w_nextState = IDLE;
                end else begin
                    mem_busy  = 1'b1;
                    memwb_wen = 1'b0;
                end
            end
            HALTED: begin
                memwb_wen = 1'b0;
                mem_busy  = 1'b1;
                halt_out  = 1'b1;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request registers keep the cache request stable for the whole access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_reqAddr <= '0;
            r_reqData <= '0;
            r_reqRen  <= 1'b0;
            r_reqWen  <= 1'b0;
            r_isLl    <= 1'b0;
            r_isSc    <= 1'b0;
        end else if (w_latch) begin
            r_reqAddr <= addr_in;
            r_reqData <= store_in;
            r_reqRen  <= dREN_in;
            r_reqWen  <= dWEN_in;
            r_isLl    <= LL_in;
            r_isSc    <= SC_in;
        end
    end

endmodule
